// File: rtl/icache_pkg.sv
// Shared icache configuration: FSM state encodings and default geometry.
//   ICACHE_INDEX_W : log2(number of lines)
//   ICACHE_ADDR_W  : physical address bits used (128 KB RAM)
package icache_pkg;

  localparam int unsigned ICACHE_INDEX_W = 7;
  localparam int unsigned ICACHE_ADDR_W  = 17;
  localparam int unsigned ICACHE_BYTES   = 4;

  typedef enum logic [1:0] {
    ICACHE_IDLE = 2'd0,
    ICACHE_FILL = 2'd1,
    ICACHE_DONE = 2'd2
  } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Tag + valid + data storage for the direct-mapped icache.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (clears valid bits)
//   clear            : synchronous clear of all valid bits
//   rd_idx           : lookup index; rd_valid_c/rd_tag_c/rd_data_c are combinational
//   we, wr_idx,
//   wr_tag, wr_data  : synchronous line write (sets the line valid)
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_W = ICACHE_INDEX_W,
  parameter int unsigned TAG_W   = ICACHE_ADDR_W - 2 - ICACHE_INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid_c,
  output logic [TAG_W-1:0]   rd_tag_c,
  output logic [31:0]        rd_data_c,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_data
);

  localparam int unsigned LINES = 2 ** INDEX_W;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags  [LINES];
  logic [31:0]      data  [LINES];

  // Valid bits: clear has priority over a same-edge write.
  always_ff @(posedge clk) begin
    if (rst || clear) valid <= '0;
    else if (we)      valid[wr_idx] <= 1'b1;
  end

  // Tag/data storage needs no reset; valid gates every use.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign rd_valid_c = valid[rd_idx];
  assign rd_tag_c   = tags[rd_idx];
  assign rd_data_c  = data[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between IF and mem_ctrl.
// Hits answer in one cycle; misses refill the word as four byte reads.
// Optional feature macro: ICACHE_PERF_EN adds hit_cnt/miss_cnt lookup counters.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   inst_fe, nxt_pc           : IF fetch request and word-aligned address
//   flush                     : invalidate all lines, abort any refill
//   inst_o, inst_pc, inst_ok  : fetched word, its address, one-cycle valid pulse
//   mem_req, mem_addr         : refill byte read request toward mem_ctrl
//   mem_gnt, mem_din          : request accepted this cycle; byte one cycle later
//   hit_cnt, miss_cnt         : (ICACHE_PERF_EN only) IDLE lookup counters
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_W = ICACHE_INDEX_W,
  parameter int unsigned ADDR_W  = ICACHE_ADDR_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_fe,
  input  logic [31:0] nxt_pc,
  input  logic        flush,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc,
  output logic        inst_ok,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_din
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned TAG_W = ADDR_W - 2 - INDEX_W;

  icache_state_t      state;
  logic [31:0]        miss_pc;
  logic [31:0]        line_buf;
  logic [2:0]         issue_cnt;
  logic [2:0]         recv_cnt;
  logic               rd_pend;

  logic               rd_valid_c;
  logic [TAG_W-1:0]   rd_tag_c;
  logic [31:0]        rd_data_c;
  logic               hit_c;
  logic               fill_done_c;
  logic [31:0]        fill_word_c;

  assign hit_c = rd_valid_c && (rd_tag_c == nxt_pc[ADDR_W-1:INDEX_W+2]);

  // The last byte completes the line on the same edge it is captured.
  assign fill_done_c = (state == ICACHE_FILL) && rd_pend && (recv_cnt == 3'd3) && !flush;
  assign fill_word_c = {mem_din, line_buf[23:0]};

  icache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .clear      (flush),
    .rd_idx     (nxt_pc[INDEX_W+1:2]),
    .rd_valid_c (rd_valid_c),
    .rd_tag_c   (rd_tag_c),
    .rd_data_c  (rd_data_c),
    .we         (fill_done_c),
    .wr_idx     (miss_pc[INDEX_W+1:2]),
    .wr_tag     (miss_pc[ADDR_W-1:INDEX_W+2]),
    .wr_data    (fill_word_c)
  );

  // Lookup / refill FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ICACHE_IDLE;
      inst_ok   <= 1'b0;
      inst_o    <= 32'd0;
      inst_pc   <= 32'd0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'd0;
      miss_pc   <= 32'd0;
      line_buf  <= 32'd0;
      issue_cnt <= 3'd0;
      recv_cnt  <= 3'd0;
      rd_pend   <= 1'b0;
    end else begin
      inst_ok <= 1'b0;
      case (state)
        ICACHE_IDLE: begin
          // A flush in the same cycle overrides the lookup entirely.
          if (inst_fe && !flush) begin
            if (hit_c) begin
              inst_ok <= 1'b1;
              inst_o  <= rd_data_c;
              inst_pc <= nxt_pc;
            end else begin
              state     <= ICACHE_FILL;
              miss_pc   <= nxt_pc;
              issue_cnt <= 3'd0;
              recv_cnt  <= 3'd0;
              rd_pend   <= 1'b0;
              mem_req   <= 1'b1;
              mem_addr  <= nxt_pc;
            end
          end
        end
        ICACHE_FILL: begin
          if (flush) begin
            // Abort: drop the request and any byte still in flight.
            state   <= ICACHE_IDLE;
            mem_req <= 1'b0;
            rd_pend <= 1'b0;
          end else begin
            rd_pend <= mem_req && mem_gnt;
            if (mem_req && mem_gnt) begin
              issue_cnt <= issue_cnt + 3'd1;
              mem_addr  <= miss_pc + 32'(issue_cnt) + 32'd1;
              if (issue_cnt == 3'd3) mem_req <= 1'b0;
            end
            if (rd_pend) begin
              line_buf[{recv_cnt[1:0], 3'b000} +: 8] <= mem_din;
              recv_cnt <= recv_cnt + 3'd1;
              if (recv_cnt == 3'd3) begin
                state   <= ICACHE_DONE;
                inst_ok <= 1'b1;
                inst_o  <= fill_word_c;
                inst_pc <= miss_pc;
              end
            end
          end
        end
        ICACHE_DONE: state <= ICACHE_IDLE;
        default:     state <= ICACHE_IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  // Counts accepted IDLE lookups; survives flush, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else if ((state == ICACHE_IDLE) && inst_fe && !flush) begin
      if (hit_c) hit_cnt  <= hit_cnt + 32'd1;
      else       miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: table of fetches plus hand-written
// flush / reset / grant-stall sequences, scoreboard on inst_ok.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_fe;
  logic [31:0] nxt_pc;
  logic        flush;
  logic [31:0] inst_o;
  logic [31:0] inst_pc;
  logic        inst_ok;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic [7:0]  mem_din;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } sb_t;
  sb_t         sb_q[$];
  logic [31:0] issue_q[$];

  typedef struct {
    logic [31:0] pc;
    bit          tog;
    int          lat;
    bit          miss;
  } vec_t;

  always #5 clk = ~clk;

  icache dut (
    .clk      (clk),
    .rst      (rst),
    .inst_fe  (inst_fe),
    .nxt_pc   (nxt_pc),
    .flush    (flush),
    .inst_o   (inst_o),
    .inst_pc  (inst_pc),
    .inst_ok  (inst_ok),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_gnt  (mem_gnt),
    .mem_din  (mem_din)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  // Memory image: word 0 holds 0x00000013, everything else a fixed pattern.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h00;
      32'd2:   return 8'h00;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'h5A ^ {a[16], 7'd0};
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-wide memory: a granted address returns its byte on the next cycle.
  initial begin
    logic        gr;
    logic [31:0] a;
    mem_din = 8'hEE;
    forever begin
      @(posedge clk);
      gr = mem_req && mem_gnt;
      a  = mem_addr;
      if (gr) issue_q.push_back(a);
      #1;
      mem_din = gr ? mem_byte(a) : 8'hEE;
    end
  end

  // Scoreboard: every inst_ok must match the oldest expected result.
  always @(negedge clk) begin
    if (inst_ok === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst_ok: got pc %h expected none", inst_pc);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("inst_o", inst_o, e.word);
        chk("inst_pc", inst_pc, e.pc);
      end
    end
  end

  // One fetch: checks latency, issued byte addresses and (via scoreboard) data.
  task automatic fetch(input logic [31:0] pc, input bit tog, input int exp_lat, input bit miss);
    int n;
    bit seen;
    sb_t e;
    e.pc   = pc;
    e.word = mem_word(pc);
    sb_q.push_back(e);
    issue_q.delete();
    @(posedge clk); #1;
    nxt_pc  = pc;
    inst_fe = 1'b1;
    mem_gnt = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      inst_fe = 1'b0;
      mem_gnt = tog ? n[0] : 1'b1;
      if (inst_ok === 1'b1) seen = 1'b1;
    end
    mem_gnt = 1'b1;
    checks++;
    if (!seen || n != exp_lat) begin
      errors++;
      $display("FAIL latency pc=%h: got %0d (seen=%0d) expected %0d", pc, n, seen, exp_lat);
    end
    chk("issue_count", 32'(issue_q.size()), miss ? 32'd4 : 32'd0);
    if (miss && issue_q.size() == 4)
      for (int k = 0; k < 4; k++) chk("issue_addr", issue_q[k], pc + 32'(k));
  endtask

  // Runs n cycles and returns how many carried inst_ok.
  task automatic quiet(input int n, output int oks);
    oks = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      inst_fe = 1'b0;
      flush   = 1'b0;
      if (inst_ok === 1'b1) oks++;
    end
  endtask

  vec_t vecs[10];

  initial begin
    int oks;
    vecs[0] = '{32'h0000_0000, 1'b0, 6, 1'b1};  // cold miss
    vecs[1] = '{32'h0000_0000, 1'b0, 1, 1'b0};  // repeat hit
    vecs[2] = '{32'h0000_0200, 1'b0, 6, 1'b1};  // same index, evicts 0x0
    vecs[3] = '{32'h0000_0000, 1'b0, 6, 1'b1};  // refill again
    vecs[4] = '{32'h0000_0000, 1'b0, 1, 1'b0};
    vecs[5] = '{32'h0001_FFFC, 1'b0, 6, 1'b1};  // top of RAM, last index
    vecs[6] = '{32'h0001_FFFC, 1'b0, 1, 1'b0};
    vecs[7] = '{32'h0000_0104, 1'b1, 9, 1'b1};  // grant toggling 1,0,1,0
    vecs[8] = '{32'h0000_0104, 1'b0, 1, 1'b0};
    vecs[9] = '{32'h0000_0200, 1'b0, 6, 1'b1};  // evicted by vecs[3]

    rst = 1'b1; inst_fe = 1'b0; flush = 1'b0; mem_gnt = 1'b1; nxt_pc = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_inst_ok", 32'(inst_ok), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_inst_o", inst_o, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) fetch(vecs[i].pc, vecs[i].tog, vecs[i].lat, vecs[i].miss);

    // Flush in cycle 3 of a refill: aborted, no inst_ok, request drops at cycle 4.
    issue_q.delete();
    @(posedge clk); #1;
    nxt_pc = 32'h0000_0300; inst_fe = 1'b1;
    oks = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      inst_fe = 1'b0;
      flush   = (c == 3);
      if (c == 4) chk("flush_mem_req", 32'(mem_req), 32'd0);
      if (inst_ok === 1'b1) oks++;
    end
    flush = 1'b0;
    chk("flush_no_ok", 32'(oks), 32'd0);
    chk("flush_issues", 32'(issue_q.size()), 32'd3);
    fetch(32'h0000_0300, 1'b0, 6, 1'b1);
    fetch(32'h0000_0104, 1'b0, 6, 1'b1);        // flush invalidated it too

    // Flush and a hit in the same cycle: flush wins.
    @(posedge clk); #1;
    nxt_pc = 32'h0000_0300; inst_fe = 1'b1; flush = 1'b1;
    quiet(4, oks);
    chk("flush_hit_no_ok", 32'(oks), 32'd0);
    fetch(32'h0000_0300, 1'b0, 6, 1'b1);

    // Reset mid-refill: outputs return to reset values, line not kept.
    @(posedge clk); #1;
    nxt_pc = 32'h0000_0400; inst_fe = 1'b1;
    @(posedge clk); #1; inst_fe = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("rstmid_mem_req", 32'(mem_req), 32'd0);
    chk("rstmid_mem_addr", mem_addr, 32'd0);
    chk("rstmid_inst_pc", inst_pc, 32'd0);
    quiet(8, oks);
    chk("rstmid_no_ok", 32'(oks), 32'd0);
    fetch(32'h0000_0300, 1'b0, 6, 1'b1);

`ifdef ICACHE_PERF_EN
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    fetch(32'h0000_0000, 1'b0, 6, 1'b1);
    fetch(32'h0000_0004, 1'b0, 6, 1'b1);
    fetch(32'h0000_0008, 1'b0, 6, 1'b1);
    fetch(32'h0000_0000, 1'b0, 1, 1'b0);
    fetch(32'h0000_0004, 1'b0, 1, 1'b0);
    fetch(32'h0000_0008, 1'b0, 1, 1'b0);
    fetch(32'h0000_0000, 1'b0, 1, 1'b0);
    fetch(32'h0000_0004, 1'b0, 1, 1'b0);
    @(posedge clk); #1;
    chk("miss_cnt", miss_cnt, 32'd3);
    chk("hit_cnt", hit_cnt, 32'd5);
    flush = 1'b1;
    quiet(2, oks);
    chk("miss_cnt_flush", miss_cnt, 32'd3);
    chk("hit_cnt_flush", hit_cnt, 32'd5);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("miss_cnt_rst", miss_cnt, 32'd0);
    chk("hit_cnt_rst", hit_cnt, 32'd0);
`endif

    quiet(3, oks);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
